game_input_conditioner: RTL and testbench

//  Front end for the in-game FSM. Synchronises and debounces the raw KEY pushbuttons and SW switches.

---
 rtl/game_input_conditioner_if.sv | 24 ++
 rtl/game_input_conditioner.sv | 192 +++++++++++++++++++
 tb/tb_game_input_conditioner.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_input_conditioner_if.sv
// Board-side bundle for the game input conditioner: raw pins and tile mask in,
// conditioned pulses and tile selection out.
interface game_input_conditioner_if;
    logic [2:0] KEY;
    logic [9:0] SW;
    logic [9:0] tile_on;
    logic       select1;
    logic       select2;
    logic       userquit;
    logic [9:0] sw_clean;
    logic [3:0] sel_index;
    logic       sel_valid;
    logic       sel_err;

    modport master (
        output KEY, SW, tile_on,
        input  select1, select2, userquit, sw_clean, sel_index, sel_valid, sel_err
    );

    modport slave (
        input  KEY, SW, tile_on,
        output select1, select2, userquit, sw_clean, sel_index, sel_valid, sel_err
    );
endinterface

// File: rtl/game_input_conditioner.sv
// Game input conditioner: synchronises and debounces KEY/SW, turns accepted
// button presses into single-cycle select1/select2/userquit/sel_err pulses and
// publishes a validated one-hot tile selection for the in-game FSM.
module game_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input logic                      CLOCK_50,
    input logic                      resetn,
    game_input_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       KEYS_UP  = 3'b111;
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_HELD  = 1'b1;

    logic [SYNC_STAGES-1:0][2:0] key_sync;
    logic [SYNC_STAGES-1:0][9:0] sw_sync;
    logic [SYNC_STAGES-1:0]      sync_vld;
    logic [2:0]                  key_s;
    logic [9:0]                  sw_s;
    logic                        sync_full;

    logic [2:0][CNT_W-1:0]       key_cnt;
    logic [2:0]                  key_stable;
    logic [2:0]                  key_prev;
    logic [2:0]                  key_fall;

    logic [CNT_W-1:0]            sw_cnt;
    logic [9:0]                  sw_last;
    logic [9:0]                  sw_clean_r;

    logic [3:0]                  ones_c;
    logic [3:0]                  idx_c;
    logic                        valid_c;
    logic [3:0]                  sel_index_r;
    logic                        sel_valid_r;

    logic [0:0]                  state;
    logic                        armed;
    logic                        select1_r;
    logic                        select2_r;
    logic                        userquit_r;
    logic                        sel_err_r;

    assign key_s     = key_sync[SYNC_STAGES-1];
    assign sw_s      = sw_sync[SYNC_STAGES-1];
    assign sync_full = sync_vld[SYNC_STAGES-1];
    assign key_fall  = key_prev & ~key_stable;

    // Synchroniser chains; sync_vld marks when the chain output is a real pin sample
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_sync <= '1;
            sw_sync  <= '0;
            sync_vld <= '0;
        end else begin
            key_sync[0] <= bus.KEY;
            sw_sync[0]  <= bus.SW;
            sync_vld[0] <= 1'b1;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                key_sync[i] <= key_sync[i-1];
                sw_sync[i]  <= sw_sync[i-1];
                sync_vld[i] <= sync_vld[i-1];
            end
        end
    end

    // Per-button debounce: accept a level once it differs from stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_cnt    <= '0;
            key_stable <= KEYS_UP;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (key_s[i] == key_stable[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_LAST) begin
                    key_stable[i] <= key_s[i];
                    key_cnt[i]    <= '0;
                end else begin
                    key_cnt[i] <= key_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Switch-vector debounce: one counter, any bit change restarts the count
    // (a change counts as the first cycle of the new value, keeping latency equal to the keys)
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sw_cnt     <= '0;
            sw_last    <= '0;
            sw_clean_r <= '0;
        end else begin
            sw_last <= sw_s;
            if (sw_s == sw_clean_r) begin
                sw_cnt <= '0;
            end else if (sw_s != sw_last) begin
                sw_cnt <= CNT_W'(1);
            end else if (sw_cnt == CNT_LAST) begin
                sw_clean_r <= sw_s;
                sw_cnt     <= '0;
            end else begin
                sw_cnt <= sw_cnt + 1'b1;
            end
        end
    end

    // Decode the sole raised switch and check it against already-matched tiles
    always_comb begin
        ones_c = '0;
        idx_c  = 4'hF;
        for (int unsigned i = 0; i < 10; i++) begin
            if (sw_clean_r[i]) begin
                ones_c = ones_c + 4'd1;
                idx_c  = 4'(i);
            end
        end
        if (ones_c != 4'd1) begin
            idx_c = 4'hF;
        end
        valid_c = (ones_c == 4'd1) && ((sw_clean_r & bus.tile_on) == '0);
    end

    // Register the selection so it lags sw_clean by one cycle
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sel_index_r <= 4'hF;
            sel_valid_r <= 1'b0;
        end else begin
            sel_index_r <= idx_c;
            sel_valid_r <= valid_c;
        end
    end

    // Shared press FSM: one event per press, quit > select1 > select2.
    // armed stays low after reset until the keys are seen released, so a press
    // straddling reset release never produces a pulse.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            key_prev   <= KEYS_UP;
            select1_r  <= 1'b0;
            select2_r  <= 1'b0;
            userquit_r <= 1'b0;
            sel_err_r  <= 1'b0;
        end else begin
            key_prev   <= key_stable;
            select1_r  <= 1'b0;
            select2_r  <= 1'b0;
            userquit_r <= 1'b0;
            sel_err_r  <= 1'b0;
            if (sync_full && (key_s == KEYS_UP) && (key_stable == KEYS_UP)) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (armed && (key_fall != '0)) begin
                        state <= ST_HELD;
                        if (key_fall[2]) begin
                            userquit_r <= 1'b1;
                        end else if (key_fall[0]) begin
                            if (sel_valid_r) select1_r <= 1'b1;
                            else             sel_err_r <= 1'b1;
                        end else begin
                            if (sel_valid_r) select2_r <= 1'b1;
                            else             sel_err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (key_stable == KEYS_UP) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.select1   = select1_r;
    assign bus.select2   = select2_r;
    assign bus.userquit  = userquit_r;
    assign bus.sel_err   = sel_err_r;
    assign bus.sw_clean  = sw_clean_r;
    assign bus.sel_index = sel_index_r;
    assign bus.sel_valid = sel_valid_r;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Testbench for game_input_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Reference model: an input is accepted once the last DEBOUNCE_CYCLES samples
// seen through the synchroniser delay all agree on a new value.
module tb_game_input_conditioner;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = S + D;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    game_input_conditioner_if bus();

    game_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20),
        .SYNC_STAGES(S)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [2:0] hk [H];
    logic [9:0] hs [H];
    int         nsamp;
    logic [2:0] m_ks, m_kp;
    logic [9:0] m_sw;
    logic       m_held, m_armed;
    logic       m_s1, m_s2, m_uq, m_err, m_val;
    logic [3:0] m_idx;

    logic [18:0] obs, exp;
    assign obs = {bus.select1, bus.select2, bus.userquit, bus.sel_err,
                  bus.sw_clean, bus.sel_index, bus.sel_valid};
    assign exp = {m_s1, m_s2, m_uq, m_err, m_sw, m_idx, m_val};

    task automatic model_reset();
        for (int k = 0; k < H; k++) begin
            hk[k] = 3'b111;
            hs[k] = '0;
        end
        nsamp = 0;
        m_ks = 3'b111; m_kp = 3'b111; m_sw = '0;
        m_held = 1'b0; m_armed = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_uq = 1'b0; m_err = 1'b0;
        m_idx = 4'hF; m_val = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] ks_old, fall;
        logic [9:0] sw_old;
        bit same;
        for (int k = H - 1; k > 0; k--) begin
            hk[k] = hk[k-1];
            hs[k] = hs[k-1];
        end
        hk[0] = bus.KEY;
        hs[0] = bus.SW;
        nsamp++;
        ks_old = m_ks;
        sw_old = m_sw;
        fall   = m_kp & ~m_ks;
        m_s1 = 1'b0; m_s2 = 1'b0; m_uq = 1'b0; m_err = 1'b0;
        if (m_held) begin
            if (ks_old == 3'b111) m_held = 1'b0;
        end else if (m_armed && fall != 3'b000) begin
            m_held = 1'b1;
            if (fall[2])      m_uq = 1'b1;
            else if (fall[0]) begin if (m_val) m_s1 = 1'b1; else m_err = 1'b1; end
            else              begin if (m_val) m_s2 = 1'b1; else m_err = 1'b1; end
        end
        if (nsamp >= S + 1 && hk[S] == 3'b111 && ks_old == 3'b111) m_armed = 1'b1;
        if ($countones(sw_old) == 1) begin
            for (int i = 0; i < 10; i++) if (sw_old[i]) m_idx = 4'(i);
            m_val = ((sw_old & bus.tile_on) == 10'h0);
        end else begin
            m_idx = 4'hF;
            m_val = 1'b0;
        end
        for (int b = 0; b < 3; b++) begin
            same = 1'b1;
            for (int k = S; k < H; k++) if (hk[k][b] != hk[S][b]) same = 1'b0;
            if (same) m_ks[b] = hk[S][b];
        end
        same = 1'b1;
        for (int k = S; k < H; k++) if (hs[k] != hs[S]) same = 1'b0;
        if (same) m_sw = hs[S];
        m_kp = ks_old;
    endtask

    // Model advances on the same edges as the DUT
    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        bus.KEY = 3'b000; bus.SW = 10'h3FF; bus.tile_on = '0; resetn = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (obs !== {4'b0000, 10'h000, 4'hF, 1'b0}) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", c, obs, {4'b0000, 10'h000, 4'hF, 1'b0});
            end
        end
        bus.KEY = 3'b111; bus.SW = '0;
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL reset_exit cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
    endtask

    task automatic test_select1_bounce();
        int n_s1 = 0;
        int first = -1;
        bus.SW = 10'h008; bus.tile_on = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t2_settle cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
        for (int i = 0; i < 10; i++) begin
            bus.KEY[0] = i[0];
            for (int c = 0; c < 2; c++) begin
                tick();
                checks++;
                if (obs !== exp) begin failures++; $display("FAIL t2_bounce cyc=%0d got=%h exp=%h", i, obs, exp); end
                n_s1 += int'(bus.select1);
            end
        end
        bus.KEY[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t2_press cyc=%0d got=%h exp=%h", c, obs, exp); end
            if (bus.select1) begin
                n_s1++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (first !== 7) begin failures++; $display("FAIL t2_latency got=%0d exp=7", first); end
        checks++;
        if (n_s1 !== 1) begin failures++; $display("FAIL t2_count got=%0d exp=1", n_s1); end
        checks++;
        if (bus.sel_index !== 4'd3) begin failures++; $display("FAIL t2_index got=%h exp=3", bus.sel_index); end
        bus.KEY[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t2_release cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
    endtask

    task automatic test_multi_switch();
        int n_s2 = 0;
        int n_err = 0;
        bus.SW = 10'h011;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t3_settle cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
        bus.KEY[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t3_press cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_s2 += int'(bus.select2);
            n_err += int'(bus.sel_err);
        end
        checks++;
        if (n_err !== 1 || n_s2 !== 0) begin failures++; $display("FAIL t3_pulses err=%0d s2=%0d exp err=1 s2=0", n_err, n_s2); end
        checks++;
        if (bus.sel_index !== 4'hF) begin failures++; $display("FAIL t3_index got=%h exp=F", bus.sel_index); end
        bus.KEY[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t3_release cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
    endtask

    task automatic test_matched_tile();
        int n_s1 = 0;
        int n_err = 0;
        bus.SW = 10'h010; bus.tile_on = 10'h010;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t4_settle cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
        checks++;
        if (bus.sel_valid !== 1'b0) begin failures++; $display("FAIL t4_valid got=%b exp=0", bus.sel_valid); end
        bus.KEY[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t4_press cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_s1 += int'(bus.select1);
            n_err += int'(bus.sel_err);
        end
        checks++;
        if (n_err !== 1 || n_s1 !== 0) begin failures++; $display("FAIL t4_pulses err=%0d s1=%0d exp err=1 s1=0", n_err, n_s1); end
        bus.KEY[0] = 1'b1; bus.tile_on = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t4_release cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
    endtask

    task automatic test_quit_priority();
        int n_s1 = 0;
        int n_uq = 0;
        int n_any = 0;
        bus.SW = 10'h020; bus.tile_on = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t5_settle cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
        bus.KEY = 3'b010;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t5_both cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_uq += int'(bus.userquit);
            n_s1 += int'(bus.select1);
        end
        checks++;
        if (n_uq !== 1 || n_s1 !== 0) begin failures++; $display("FAIL t5_priority uq=%0d s1=%0d exp uq=1 s1=0", n_uq, n_s1); end
        bus.KEY = 3'b011;
        for (int c = 0; c < 10; c++) tick();
        bus.KEY = 3'b010;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t5_repress cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_any += $countones(obs[18:15]);
        end
        checks++;
        if (n_any !== 0) begin failures++; $display("FAIL t5_held_ignore pulses=%0d exp=0", n_any); end
        bus.KEY = 3'b111;
        for (int c = 0; c < 12; c++) tick();
        bus.KEY = 3'b110;
        n_s1 = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t5_after cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_s1 += int'(bus.select1);
        end
        checks++;
        if (n_s1 !== 1) begin failures++; $display("FAIL t5_select1 got=%0d exp=1", n_s1); end
        bus.KEY = 3'b111;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_reset_straddle();
        int n_any = 0;
        int n_s1 = 0;
        bus.KEY = 3'b110;
        for (int c = 0; c < 3; c++) tick();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== {4'b0000, 10'h000, 4'hF, 1'b0}) begin failures++; $display("FAIL t6_in_reset got=%h exp=%h", obs, {4'b0000, 10'h000, 4'hF, 1'b0}); end
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t6_straddle cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_any += $countones(obs[18:15]);
        end
        checks++;
        if (n_any !== 0) begin failures++; $display("FAIL t6_no_pulse pulses=%0d exp=0", n_any); end
        bus.KEY = 3'b111;
        for (int c = 0; c < 12; c++) tick();
        bus.KEY = 3'b110;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL t6_repress cyc=%0d got=%h exp=%h", c, obs, exp); end
            n_s1 += int'(bus.select1);
        end
        checks++;
        if (n_s1 !== 1) begin failures++; $display("FAIL t6_select1 got=%0d exp=1", n_s1); end
        bus.KEY = 3'b111;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_random();
        int dwell;
        logic [9:0] onehot;
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 9) < 6) bus.KEY = 3'b111;
            else                          bus.KEY = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       bus.SW = '0;
                3:       bus.SW = 10'($urandom_range(0, 1023));
                default: begin onehot = 10'd1 << $urandom_range(0, 9); bus.SW = onehot; end
            endcase
            bus.tile_on = 10'($urandom()) & 10'($urandom());
            dwell = $urandom_range(1, 10);
            for (int c = 0; c < dwell; c++) begin
                tick();
                checks++;
                if (obs !== exp) begin failures++; $display("FAIL rand_model it=%0d got=%h exp=%h", it, obs, exp); end
                checks++;
                if ($countones(obs[18:15]) > 1) begin failures++; $display("FAIL rand_exclusive it=%0d pulses=%b exp=at most one", it, obs[18:15]); end
            end
        end
        bus.KEY = 3'b111;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL rand_drain cyc=%0d got=%h exp=%h", c, obs, exp); end
        end
    endtask

    initial begin
        bus.KEY = 3'b111; bus.SW = '0; bus.tile_on = '0;
        test_reset();
        test_select1_bounce();
        test_multi_switch();
        test_matched_tile();
        test_quit_priority();
        test_reset_straddle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
